// File: rtl/adc_pkg.sv
// Shared definitions for the ADC acquisition sequencer slice.
// Holds the controller state encoding, default timing limits and the layout
// of the host register-access word forwarded to the SPI ADC interface block.
package adc_pkg;

    localparam int unsigned ADC_CNT_WIDTH  = 32;
    localparam int unsigned ADC_MIN_PERIOD = 16;

    // Register-access word layout
    localparam int unsigned REG_WORD_W    = 32;
    localparam int unsigned REG_WRITE_BIT = 23;
    localparam int unsigned REG_ADDR_MSB  = 22;
    localparam int unsigned REG_ADDR_LSB  = 8;
    localparam int unsigned REG_DATA_MSB  = 7;
    localparam int unsigned REG_DATA_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REG   = 2'd1,
        ST_ACQ   = 2'd2,
        ST_DRAIN = 2'd3
    } acq_state_e;

    typedef struct packed {
        logic [7:0]  rsvd;
        logic        write;
        logic [14:0] addr;
        logic [7:0]  data;
    } reg_word_t;

    // Word that takes the ADC out of register-access mode
    localparam reg_word_t REG_EXIT_WORD = '{rsvd: 8'h00, write: 1'b1, addr: 15'h7FFF, data: 8'h00};

endpackage

// File: rtl/adc_acq_sequencer_if.sv
// AXI-Stream style register-word channel (tdata/tvalid/tready).
// master: drives tdata/tvalid, receives tready.
// slave : receives tdata/tvalid, drives tready.
interface adc_acq_sequencer_if;

    adc_pkg::reg_word_t tdata;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/adc_trig_timer.sv
// Conversion-trigger period timer.
// Ports: aclk/aresetn; load clears the counter so the next enabled cycle fires;
// en lets the counter run; period is the reload interval (>= 1);
// trigger is a registered one-cycle pulse, period cycles apart while enabled.
module adc_trig_timer #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 load,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] period,
    output logic                 trigger
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 trigger_q, trigger_d;

    // Down-counter: fire at zero and reload with period-1
    always_comb begin
        cnt_d     = cnt_q;
        trigger_d = 1'b0;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == '0) begin
                trigger_d = 1'b1;
                cnt_d     = period - CNT_WIDTH'(1);
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q     <= '0;
            trigger_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            trigger_q <= trigger_d;
        end
    end

    assign trigger = trigger_q;

endmodule

// File: rtl/adc_acq_sequencer.sv
// SPI ADC front-end sequencer.
// Issues conversion triggers at a programmed rate for a programmed number of
// samples, counts accepted samples on the monitored ADC output handshake,
// flags overruns, and forwards host register words to the ADC interface
// while no acquisition is running.
// Ports:
//   aclk, aresetn           clock, async active-low reset
//   start, stop             acquisition control pulses
//   cfg_period              trigger period (clamped to MIN_PERIOD), sampled at start
//   cfg_num_samples         samples per run, 0 = continuous, sampled at start
//   trigger                 conversion trigger pulse
//   s_axis_reg / m_axis_reg register word in from host / out to ADC interface
//   adc_tvalid, adc_tready  monitored ADC data handshake
//   busy, done, overrun     status
//   sample_count            samples accepted in current/last run
module adc_acq_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = ADC_CNT_WIDTH,
    parameter int unsigned MIN_PERIOD = ADC_MIN_PERIOD
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       start,
    input  logic                       stop,
    input  logic [CNT_WIDTH-1:0]       cfg_period,
    input  logic [CNT_WIDTH-1:0]       cfg_num_samples,
    output logic                       trigger,
    adc_acq_sequencer_if.slave         s_axis_reg,
    adc_acq_sequencer_if.master        m_axis_reg,
    input  logic                       adc_tvalid,
    input  logic                       adc_tready,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    output logic [CNT_WIDTH-1:0]       sample_count
);

    localparam int unsigned TMO_WIDTH = CNT_WIDTH + 2;

    acq_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [CNT_WIDTH-1:0] sample_q, sample_d;
    logic [TMO_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
    logic                 overrun_q, overrun_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 s_tready_q, s_tready_d;
    logic                 m_tvalid_q, m_tvalid_d;
    reg_word_t            m_tdata_q, m_tdata_d;

    logic                 timer_load;
    logic                 timer_en;
    logic                 sample_acc_c;
    logic [CNT_WIDTH-1:0] outstanding_c;
    logic [TMO_WIDTH-1:0] tmo_last_c;

    adc_trig_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_trig_timer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (timer_load),
        .en      (timer_en),
        .period  (period_q),
        .trigger (trigger)
    );

    // Samples only count while a run is active (ACQ or DRAIN)
    assign sample_acc_c  = adc_tvalid && adc_tready && ((state_q == ST_ACQ) || (state_q == ST_DRAIN));
    assign outstanding_c = issued_q - sample_q;
    // Last DRAIN cycle before giving up: 4*period cycles after entry
    assign tmo_last_c    = {period_q, 2'b00} - TMO_WIDTH'(1);

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        num_d       = num_q;
        issued_d    = issued_q;
        sample_d    = sample_q;
        drain_cnt_d = drain_cnt_q;
        overrun_d   = overrun_q;
        done_d      = 1'b0;
        m_tvalid_d  = m_tvalid_q;
        m_tdata_d   = m_tdata_q;
        timer_load  = 1'b0;
        timer_en    = 1'b0;

        if (sample_acc_c) begin
            sample_d = sample_q + CNT_WIDTH'(1);
        end

        // The visible trigger pulse is the issue event
        if (trigger) begin
            issued_d = issued_q + CNT_WIDTH'(1);
            if (outstanding_c != '0) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Register handshake takes priority over start
                if (s_axis_reg.tvalid && s_tready_q) begin
                    m_tdata_d  = s_axis_reg.tdata;
                    m_tvalid_d = 1'b1;
                    state_d    = ST_REG;
                end else if (start) begin
                    period_d   = (cfg_period < CNT_WIDTH'(MIN_PERIOD)) ? CNT_WIDTH'(MIN_PERIOD) : cfg_period;
                    num_d      = cfg_num_samples;
                    sample_d   = '0;
                    issued_d   = '0;
                    overrun_d  = 1'b0;
                    timer_load = 1'b1;
                    state_d    = ST_ACQ;
                end
            end
            ST_REG: begin
                if (m_axis_reg.tready) begin
                    m_tvalid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_ACQ: begin
                timer_en = 1'b1;
                if (stop || ((num_q != '0) && (issued_d == num_q))) begin
                    drain_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A trigger still on the wire has not been counted yet
                if (!trigger && (issued_q == sample_q)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (drain_cnt_q == tmo_last_c) begin
                    overrun_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + TMO_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        s_tready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            period_q    <= CNT_WIDTH'(MIN_PERIOD);
            num_q       <= '0;
            issued_q    <= '0;
            sample_q    <= '0;
            drain_cnt_q <= '0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            sample_q    <= sample_d;
            drain_cnt_q <= drain_cnt_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
        end
    end

    assign s_axis_reg.tready = s_tready_q;
    assign m_axis_reg.tvalid = m_tvalid_q;
    assign m_axis_reg.tdata  = m_tdata_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign overrun           = overrun_q;
    assign sample_count      = sample_q;

endmodule

// File: doc/adc_acq_sequencer.md
Name: adc_acq_sequencer

Overview:
Sequences the SPI ADC front end: issues the conversion trigger at a programmed rate for a programmed number of samples, and arbitrates register-access words from the host onto the ADC's register AXI-Stream input.
Sits between the PS-side config/register FIFOs and the SPI ADC interface block.
Observes the ADC conversion output stream handshake to count completed samples and detect overruns.
Register access is permitted only while no acquisition is running.

Parameters:
CNT_WIDTH, 32, width of period and sample counters
MIN_PERIOD, 16, minimum trigger period in aclk cycles; smaller programmed values are clamped to this

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begin acquisition (ignored unless IDLE)
stop  in  1  single-cycle pulse; end acquisition after in-flight sample
cfg_period  in  CNT_WIDTH  trigger period in aclk cycles, sampled at start
cfg_num_samples  in  CNT_WIDTH  samples per acquisition, sampled at start; 0 = continuous
trigger  out  1  conversion trigger pulse to the ADC interface
s_axis_reg_tdata  in  32  host register word
s_axis_reg_tvalid  in  1  host register valid
s_axis_reg_tready  out  1  host register ready
m_axis_reg_tdata  out  32  register word to the ADC interface
m_axis_reg_tvalid  out  1  register valid to the ADC interface
m_axis_reg_tready  in  1  ready from the ADC interface
adc_tvalid  in  1  monitored ADC data tvalid
adc_tready  in  1  monitored ADC data tready
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when ACQ/DRAIN returns to IDLE
overrun  out  1  sticky; a trigger was issued with a sample still outstanding; cleared at start
sample_count  out  CNT_WIDTH  samples accepted in the current or last acquisition

Behaviour:
- Reset values: trigger=0, m_axis_reg_tvalid=0, m_axis_reg_tdata=0, s_axis_reg_tready=0, busy=0, done=0, overrun=0, sample_count=0; state=IDLE.
- Reset is asynchronous; asserting aresetn mid-operation returns to IDLE immediately with all counters cleared.

States: IDLE, REG, ACQ, DRAIN.

IDLE:
- s_axis_reg_tready=1.
- On s_axis_reg handshake: latch tdata into m_axis_reg_tdata, set m_axis_reg_tvalid, go to REG.
- Else on start: latch period = max(cfg_period, MIN_PERIOD) and num_samples, clear sample_count and overrun, load the period counter with 0, go to ACQ.
- Start and a register handshake in the same cycle: the register handshake wins; start is dropped.

REG:
- s_axis_reg_tready=0.
- Hold m_axis_reg_tvalid and tdata stable until m_axis_reg_tready is seen.
- Then drop tvalid and return to IDLE the following cycle.
- start is ignored in REG.

ACQ:
- s_axis_reg_tready=0.
- The period counter decrements each cycle.
- At 0: assert trigger for exactly one cycle and reload with period-1. The first trigger is therefore 1 cycle after entering ACQ.
- Count issued triggers (issued_count).
- outstanding = issued_count - sample_count.
- A trigger issued while outstanding != 0 sets overrun; the trigger is still issued.
- sample_count increments on each cycle with adc_tvalid & adc_tready.
- When num_samples != 0 and issued_count reaches num_samples, go to DRAIN. No further triggers.
- stop goes to DRAIN. If stop coincides with a trigger, that trigger is issued.

DRAIN:
- Wait until sample_count == issued_count, then pulse done and go to IDLE.
- Drain timeout: 4*period cycles, after which the block returns to IDLE anyway with overrun set.

Width rules:
- All counters are CNT_WIDTH unsigned.
- In continuous mode sample_count and issued_count wrap modulo 2^CNT_WIDTH; outstanding is computed modulo as well.

Decomposition:
- Shared package adc_pkg: state encoding (IDLE/REG/ACQ/DRAIN), MIN_PERIOD default, register word field constants (write bit 23, address field [22:8], data [7:0], exit-register word).
- One natural sub-module, adc_trig_timer: period counter with load/enable, producing the one-cycle trigger pulse.

Test Plan:
1. Reset, then cfg_period=20, cfg_num_samples=4, pulse start; ADC model returns each sample 10 cycles after trigger -> triggers at cycles 1, 21, 41, 61 after ACQ entry; done pulse after the 4th sample; sample_count=4, overrun=0.
2. cfg_period=5 -> spacing clamped to 16 cycles between trigger pulses.
3. Host register word 0x00A01400 with m_axis_reg_tready held low 7 cycles -> tvalid and tdata stable; s_axis_reg_tready=0 throughout; IDLE 1 cycle after handshake. start pulsed during REG -> no trigger.
4. cfg_num_samples=0, period=32, stop after 5 triggers -> exactly 5 triggers; DRAIN waits for the 5th sample, then done.
5. ADC model takes 40 cycles per sample with period=16 -> overrun set on the 2nd trigger; cleared by the next start.
6. Assert aresetn low mid-ACQ while a trigger is high -> trigger, busy and counters are 0 within the reset cycle; state IDLE after release.
